// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Holds the FSM state encoding, the default operand width and the counter sizing rule.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DEFAULT_WIDTH = 8;

   // The bit counter must be able to represent WIDTH itself.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/done handshake and operand/result bundle for serial_adder_ctrl.
// The sub select is present only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             overflow;

   modport master (
      output start, a, b, c_in,
`ifdef SERIAL_ADDER_SUB_EN
      output sub,
`endif
      input  busy, done, sum, c_out, overflow
   );

   modport slave (
      input  start, a, b, c_in,
`ifdef SERIAL_ADDER_SUB_EN
      input  sub,
`endif
      output busy, done, sum, c_out, overflow
   );

endinterface

// File: rtl/fulladder.sv
// Single-bit full-adder cell; the only arithmetic element of the serial adder.
module fulladder (
   input  logic a,
   input  logic b,
   input  logic c_in,
   output logic s,
   output logic c_out
);

   assign s     = a ^ b ^ c_in;
   assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell stepped LSB first over WIDTH cycles.
// Define SERIAL_ADDER_SUB_EN to add the sub select (a - b via ~b and carry-in 1).
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)(
   input  logic           clk,
   input  logic           rst_n,
   serial_adder_if.slave  bus
);

   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             carry_prev_q, carry_prev_d;
   logic             c_out_q, c_out_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;
   logic             busy;
   logic             op_sub;
   logic             fa_s;
   logic             fa_c;

`ifdef SERIAL_ADDER_SUB_EN
   assign op_sub = bus.sub;
`else
   assign op_sub = 1'b0;
`endif

   fulladder u_fa (
      .a     (a_sh_q[0]),
      .b     (b_sh_q[0]),
      .c_in  (carry_q),
      .s     (fa_s),
      .c_out (fa_c)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         a_sh_q       <= '0;
         b_sh_q       <= '0;
         sum_sh_q     <= '0;
         sum_q        <= '0;
         cnt_q        <= '0;
         carry_q      <= 1'b0;
         carry_prev_q <= 1'b0;
         c_out_q      <= 1'b0;
         ovf_q        <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_sh_q       <= a_sh_d;
         b_sh_q       <= b_sh_d;
         sum_sh_q     <= sum_sh_d;
         sum_q        <= sum_d;
         cnt_q        <= cnt_d;
         carry_q      <= carry_d;
         carry_prev_q <= carry_prev_d;
         c_out_q      <= c_out_d;
         ovf_q        <= ovf_d;
         done_q       <= done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      a_sh_d       = a_sh_q;
      b_sh_d       = b_sh_q;
      sum_sh_d     = sum_sh_q;
      sum_d        = sum_q;
      cnt_d        = cnt_q;
      carry_d      = carry_q;
      carry_prev_d = carry_prev_q;
      c_out_d      = c_out_q;
      ovf_d        = ovf_q;
      done_d       = 1'b0;
      case (state_q)
         IDLE: begin
            // Subtraction reuses the adder: a + ~b + 1.
            if (bus.start) begin
               a_sh_d  = bus.a;
               b_sh_d  = op_sub ? ~bus.b : bus.b;
               carry_d = op_sub ? 1'b1 : bus.c_in;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
            sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
            carry_d  = fa_c;
            cnt_d    = cnt_q + 1'b1;
            // The carry entering the MSB is kept for the signed overflow test.
            if (cnt_q == LAST_BIT) begin
               carry_prev_d = carry_q;
               state_d      = DONE;
            end
         end
         DONE: begin
            sum_d   = sum_sh_q;
            c_out_d = carry_q;
            ovf_d   = carry_prev_q ^ carry_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      busy = (state_q == RUN);
   end

   assign bus.busy     = busy;
   assign bus.done     = done_q;
   assign bus.sum      = sum_q;
   assign bus.c_out    = c_out_q;
   assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) using an expected-result queue.
// Subtraction cases run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;

   localparam int WIDTH = 8;

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             c_out;
      logic             ovf;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   serial_adder_if #(.WIDTH(WIDTH)) bus ();

   serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   n_checks     = 0;
   int   n_fail       = 0;
   int   done_pulses  = 0;
   int   overlap_seen = 0;

   // Independent arithmetic model: wide add plus a separate 7-bit add for the MSB carry-in.
   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic cin, input logic sub);
      exp_t           r;
      logic [WIDTH-1:0] bb;
      logic           c0;
      logic [WIDTH:0] full;
      logic [WIDTH-1:0] low;
      bb   = sub ? ~b : b;
      c0   = sub ? 1'b1 : cin;
      full = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, c0};
      low  = {1'b0, a[WIDTH-2:0]} + {1'b0, bb[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, c0};
      r.sum   = full[WIDTH-1:0];
      r.c_out = full[WIDTH];
      r.ovf   = low[WIDTH-1] ^ full[WIDTH];
      return r;
   endfunction

   always begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) done_pulses++;
      if (bus.busy === 1'b1 && bus.done === 1'b1) overlap_seen++;
   end

   task automatic drive_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin, input logic sub, input bit push);
      bus.a    = a;
      bus.b    = b;
      bus.c_in = cin;
`ifdef SERIAL_ADDER_SUB_EN
      bus.sub  = sub;
`endif
      if (push) exp_q.push_back(model(a, b, cin, sub));
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int cyc, output bit seen);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < limit) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.done === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.c_in  = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      bus.sub   = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got=%b want=0", bus.busy); end
      n_checks++;
      if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got=%b want=0", bus.done); end
      n_checks++;
      if (bus.sum !== '0) begin n_fail++; $display("[TB] FAIL reset_sum got=%h want=00", bus.sum); end
      n_checks++;
      if (bus.c_out !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_c_out got=%b want=0", bus.c_out); end
      n_checks++;
      if (bus.overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overflow got=%b want=0", bus.overflow); end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed_add;
      logic [WIDTH-1:0] va [3] = '{8'h5A, 8'hFF, 8'h00};
      logic [WIDTH-1:0] vb [3] = '{8'h3C, 8'h01, 8'h00};
      logic             vc [3] = '{1'b0, 1'b0, 1'b1};
      int   cyc;
      bit   seen;
      exp_t want;
      exp_t got;
      exp_q.delete();
      for (int i = 0; i < 3; i++) begin
         drive_op(va[i], vb[i], vc[i], 1'b0, 1'b1);
         n_checks++;
         if (bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL add%0d_busy got=%b want=1", i, bus.busy); end
         wait_done(20, cyc, seen);
         n_checks++;
         if (!seen || cyc != WIDTH + 1) begin
            n_fail++; $display("[TB] FAIL add%0d_latency got=%0d seen=%b want=%0d", i, cyc, seen, WIDTH + 1);
         end
         if (seen && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = '{sum: bus.sum, c_out: bus.c_out, ovf: bus.overflow};
            n_checks++;
            if (got !== want) begin
               n_fail++;
               $display("[TB] FAIL add%0d_result got sum=%h c=%b ov=%b want sum=%h c=%b ov=%b",
                        i, got.sum, got.c_out, got.ovf, want.sum, want.c_out, want.ovf);
            end
         end
         @(posedge clk);
         #1;
         n_checks++;
         if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL add%0d_done_pulse got=%b want=0", i, bus.done); end
      end
   endtask

   task automatic test_back_to_back;
      int   cyc    = 0;
      int   first  = -1;
      int   second = -1;
      exp_t want;
      exp_t got;
      exp_q.delete();
      bus.a     = 8'h11;
      bus.b     = 8'h22;
      bus.c_in  = 1'b0;
      bus.start = 1'b1;
      exp_q.push_back(model(8'h11, 8'h22, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      bus.a = 8'hC3;
      exp_q.push_back(model(8'hC3, 8'h22, 1'b0, 1'b0));
      while (second < 0 && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
         if (first >= 0 && cyc == first + 1) begin
            bus.start = 1'b0;
            n_checks++;
            if (bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_reaccept_busy got=%b want=1", bus.busy); end
         end
         if (bus.done === 1'b1) begin
            if (exp_q.size() > 0) begin
               want = exp_q.pop_front();
               got  = '{sum: bus.sum, c_out: bus.c_out, ovf: bus.overflow};
               n_checks++;
               if (got !== want) begin
                  n_fail++;
                  $display("[TB] FAIL b2b_result got sum=%h c=%b ov=%b want sum=%h c=%b ov=%b",
                           got.sum, got.c_out, got.ovf, want.sum, want.c_out, want.ovf);
               end
            end
            if (first < 0) first = cyc;
            else second = cyc;
         end
      end
      bus.start = 1'b0;
      n_checks++;
      if (first != WIDTH + 1) begin n_fail++; $display("[TB] FAIL b2b_first_latency got=%0d want=%0d", first, WIDTH + 1); end
      n_checks++;
      if (second < 0 || second - first != WIDTH + 2) begin
         n_fail++; $display("[TB] FAIL b2b_spacing got=%0d want=%0d", second - first, WIDTH + 2);
      end
      repeat (WIDTH + 3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_run;
      int   cyc;
      bit   seen;
      bit   spurious = 1'b0;
      exp_t want;
      exp_t got;
      exp_q.delete();
      drive_op(8'hAA, 8'h55, 1'b1, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy got=%b want=0", bus.busy); end
      n_checks++;
      if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_done got=%b want=0", bus.done); end
      n_checks++;
      if (bus.sum !== '0) begin n_fail++; $display("[TB] FAIL midrst_sum got=%h want=00", bus.sum); end
      rst_n = 1'b1;
      for (int i = 0; i < WIDTH + 4; i++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1 || bus.busy === 1'b1) spurious = 1'b1;
      end
      n_checks++;
      if (spurious) begin n_fail++; $display("[TB] FAIL midrst_discard got=activity want=idle"); end
      drive_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);
      wait_done(20, cyc, seen);
      n_checks++;
      if (!seen || exp_q.size() == 0) begin
         n_fail++; $display("[TB] FAIL midrst_recover got=seen%b want=seen1", seen);
      end else begin
         want = exp_q.pop_front();
         got  = '{sum: bus.sum, c_out: bus.c_out, ovf: bus.overflow};
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL midrst_result got sum=%h c=%b ov=%b want sum=%h c=%b ov=%b",
                     got.sum, got.c_out, got.ovf, want.sum, want.c_out, want.ovf);
         end
      end
      @(posedge clk);
      #1;
   endtask

`ifdef SERIAL_ADDER_SUB_EN
   task automatic test_sub;
      logic [WIDTH-1:0] va [2] = '{8'h10, 8'h80};
      logic [WIDTH-1:0] vb [2] = '{8'h20, 8'h01};
      int   cyc;
      bit   seen;
      exp_t want;
      exp_t got;
      exp_q.delete();
      for (int i = 0; i < 2; i++) begin
         drive_op(va[i], vb[i], 1'b0, 1'b1, 1'b1);
         wait_done(20, cyc, seen);
         n_checks++;
         if (!seen || exp_q.size() == 0) begin
            n_fail++; $display("[TB] FAIL sub%0d_done got=seen%b want=seen1", i, seen);
         end else begin
            want = exp_q.pop_front();
            got  = '{sum: bus.sum, c_out: bus.c_out, ovf: bus.overflow};
            n_checks++;
            if (got !== want) begin
               n_fail++;
               $display("[TB] FAIL sub%0d_result got sum=%h c=%b ov=%b want sum=%h c=%b ov=%b",
                        i, got.sum, got.c_out, got.ovf, want.sum, want.c_out, want.ovf);
            end
         end
      end
      bus.sub = 1'b0;
      @(posedge clk);
      #1;
   endtask
`endif

   task automatic test_random;
      int   cyc;
      bit   seen;
      int   base_pulses;
      int   timeouts = 0;
      exp_t want;
      exp_t got;
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rc;
      exp_q.delete();
      base_pulses = done_pulses;
      for (int i = 0; i < 1000; i++) begin
         ra = WIDTH'($urandom_range(0, 255));
         rb = WIDTH'($urandom_range(0, 255));
         rc = 1'($urandom_range(0, 1));
         drive_op(ra, rb, rc, 1'b0, 1'b1);
         wait_done(20, cyc, seen);
         if (!seen) begin
            timeouts++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end else if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = '{sum: bus.sum, c_out: bus.c_out, ovf: bus.overflow};
            n_checks++;
            if (got !== want) begin
               n_fail++;
               $display("[TB] FAIL rand%0d a=%h b=%h cin=%b got sum=%h c=%b ov=%b want sum=%h c=%b ov=%b",
                        i, ra, rb, rc, got.sum, got.c_out, got.ovf, want.sum, want.c_out, want.ovf);
            end
         end
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (timeouts != 0) begin n_fail++; $display("[TB] FAIL rand_timeouts got=%0d want=0", timeouts); end
      n_checks++;
      if (done_pulses - base_pulses != 1000) begin
         n_fail++; $display("[TB] FAIL rand_done_count got=%0d want=1000", done_pulses - base_pulses);
      end
      n_checks++;
      if (overlap_seen != 0) begin n_fail++; $display("[TB] FAIL busy_done_overlap got=%0d want=0", overlap_seen); end
   endtask

   initial begin
      test_reset();
      test_directed_add();
      test_back_to_back();
      test_reset_mid_run();
`ifdef SERIAL_ADDER_SUB_EN
      test_sub();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller. Sequences one full-adder cell over WIDTH clock cycles to add two WIDTH-bit operands, LSB first. Uses a start/done handshake. This is the area-minimal adder path beside the combinational full-adder cell, for use where throughput is not critical.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- c_in  input  1  carry-in, captured on accepted start
- sub  input  1  subtract select, captured on accepted start (present only with SERIAL_ADDER_SUB_EN)
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse when the result becomes valid
- sum  output  WIDTH  result, held until the next accepted start
- c_out  output  1  final carry-out, held with sum
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB), held with sum
- One clock; reset is synchronous and active-low.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE
  - start=1 → capture a, b and carry (c_in) into shift registers, clear the bit counter, go to RUN.
  - start=0 → stay in IDLE.
- RUN, each cycle:
  - Drive the full-adder cell with a_sh[0], b_sh[0], carry.
  - Shift a_sh and b_sh right by one.
  - Shift the cell sum into the MSB of sum_sh (sum_sh shifts right).
  - carry <= cell c_out.
  - counter++.
  - On the cycle with counter==WIDTH-1, also latch carry_prev <= carry, i.e. the carry into the MSB.
  - After the WIDTH-th bit → DONE.
- DONE, for one cycle:
  - sum <= sum_sh, c_out <= carry, overflow <= carry_prev ^ carry, done=1.
  - Then go to IDLE.
- start while in RUN or DONE is ignored and not queued.
- Counter width is $clog2(WIDTH+1). Arithmetic is modulo 2^WIDTH, and the carry is reported separately.
- Reset (rst_n=0 on any edge, including mid-RUN):
  - FSM goes to IDLE; the in-flight operation is discarded.
  - busy=0, done=0, sum=0, c_out=0, overflow=0; internal shift registers and counter cleared.

## Timing
- start accepted at edge N → busy=1 from edge N through edge N+WIDTH.
- done=1 for the single cycle following edge N+WIDTH+1. sum, c_out and overflow are valid from that edge on.
- Total latency is WIDTH+1 cycles from accepted start to done. The earliest next accepted start is the cycle done is high is not possible; the next start is accepted at edge N+WIDTH+2 (back in IDLE).
- Outputs are registered; there is no combinational path from inputs to outputs.
- busy and done are never high in the same cycle.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - Adds the sub port.
  - On accepted start with sub=1, capture ~b and force the initial carry to 1; c_in is ignored. The result is a−b.
  - c_out=1 means no borrow.
  - overflow is the signed-subtraction overflow.
- SERIAL_ADDER_SUB_EN undefined: the sub port is absent and the block is add-only.

## Structure
- Shared package serial_adder_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default width constant;
  - a counter-width function.
- One sub-module: the existing fulladder cell (ports a, b, c_in, s, c_out), instantiated exactly once as the sole arithmetic element. No other adders are allowed.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, c_in=0, start pulse → done after 9 cycles; sum=0x96, c_out=0, overflow=1.
- a=0xFF, b=0x01, c_in=0 → sum=0x00, c_out=1, overflow=0. Also a=0x00, b=0x00, c_in=1 → sum=0x01, c_out=0.
- start held high continuously with a changed mid-RUN:
  - the result reflects the operands captured at acceptance;
  - back-to-back operations are spaced WIDTH+2 cycles apart.
- rst_n=0 at RUN cycle 4 → next cycle busy=0, done=0, sum=0; a subsequent start completes normally.
- SERIAL_ADDER_SUB_EN, sub=1, a=0x10, b=0x20 → sum=0xF0, c_out=0, overflow=0. a=0x80, b=0x01 → sum=0x7F, c_out=1, overflow=1.
- Random operands, 1000 operations: {c_out,sum} equals a+b+c_in each time, and done pulses exactly once per accepted start.
